sqm_core: RTL and testbench

- Sequential shift-and-add unsigned multiplier: 8-bit multiplicand A × 4-bit multiplier B.
- Returns the low 8 bits of the 12-bit product on Y, plus an overflow flag for the discarded high bits.
- Datapath helper for the processor ALU/execute stage; one multiplication in flight at a time, start/busy/done handshake.

---
 rtl/sqm_core_if.sv | 21 ++
 rtl/sqm_core.sv | 98 +++++++++
 tb/tb_sqm_core.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sqm_core_if.sv
// Start/busy/done handshake and operand/result bus for the sqm_core multiplier.
`default_nettype none

interface sqm_core_if #(
   parameter int AW = 8,
   parameter int BW = 4,
   parameter int YW = 8
);
   logic          start;
   logic [AW-1:0] A;
   logic [BW-1:0] B;
   logic [YW-1:0] Y;
   logic          ovf;
   logic          busy;
   logic          done;

   modport master (output start, A, B, input Y, ovf, busy, done);
   modport slave  (input start, A, B, output Y, ovf, busy, done);
endinterface

`default_nettype wire

// File: rtl/sqm_core.sv
// Sequential shift-and-add unsigned multiplier, AW x BW bits, BW iterations per op.
// Y carries the low YW product bits; ovf flags any non-zero bits above them.
`default_nettype none

module sqm_core #(
   parameter int AW = 8,
   parameter int BW = 4,
   parameter int YW = 8
) (
   input  wire logic   clk,
   input  wire logic   reset,
   sqm_core_if.slave   bus
);
   localparam int PW = AW + BW;
   localparam int CW = $clog2(BW + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state_q;
   logic [PW-1:0]   acc_q;
   logic [PW-1:0]   mcand_q;
   logic [BW-1:0]   mplier_q;
   logic [CW-1:0]   count_q;
   logic [YW-1:0]   y_q;
   logic            ovf_q;
   logic            busy_q;
   logic            done_q;

   logic [PW-1:0]   acc_d;
   logic            ovf_d;
   logic            last_iter;

   // Unsigned operands: the PW-bit sum can never exceed PW bits, so no carry out.
   assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign last_iter = (count_q == CW'(BW - 1));

   generate
      if (YW < PW) begin : g_ovf
         assign ovf_d = |acc_d[PW-1:YW];
      end else begin : g_no_ovf
         assign ovf_d = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
         y_q      <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  mcand_q  <= {{BW{1'b0}}, bus.A};
                  mplier_q <= bus.B;
                  acc_q    <= '0;
                  count_q  <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + CW'(1);
               // Always run all BW iterations so latency is operand-independent.
               if (last_iter) begin
                  y_q     <= acc_d[YW-1:0];
                  ovf_q   <= ovf_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.Y    = y_q;
   assign bus.ovf  = ovf_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sqm_core.sv
// Self-checking bench for sqm_core: vector table plus hand-written handshake corner cases.
`default_nettype none

module tb_sqm_core;
   logic clk;
   logic reset;

   sqm_core_if #(.AW(8), .BW(4), .YW(8)) bus ();

   sqm_core #(.AW(8), .BW(4), .YW(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] y;
      logic       ovf;
   } vec_t;

   typedef struct {
      logic [7:0] y;
      logic       ovf;
   } res_t;

   vec_t       vecs [9];
   res_t       exp_q [$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] last_y  = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset && bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            check("Y", 32'(bus.Y), 32'(e.y));
            check("ovf", 32'(bus.ovf), 32'(e.ovf));
            last_y = e.y;
         end
      end
   end

   task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] ey, input logic eo);
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      exp_q.push_back('{ey, eo});
      @(negedge clk);
      bus.start = 1'b0;
      bus.A     = 8'($urandom);
      bus.B     = 4'($urandom);
      check("busy_run", 32'(bus.busy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_early_done", 32'(bus.done), 32'd0);
         check("Y_hold", 32'(bus.Y), 32'(last_y));
      end
      @(negedge clk);
      check("done_latency", 32'(bus.done), 32'd1);
      check("busy_clear", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("done_pulse", 32'(bus.done), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h0F, 4'h3, 8'h2D, 1'b0};
      vecs[1] = '{8'hFF, 4'hF, 8'hF1, 1'b1};
      vecs[2] = '{8'h10, 4'hF, 8'hF0, 1'b0};
      vecs[3] = '{8'h00, 4'hA, 8'h00, 1'b0};
      vecs[4] = '{8'h5A, 4'h0, 8'h00, 1'b0};
      vecs[5] = '{8'h80, 4'h2, 8'h00, 1'b1};
      vecs[6] = '{8'h01, 4'h1, 8'h01, 1'b0};
      vecs[7] = '{8'hFF, 4'h1, 8'hFF, 1'b0};
      vecs[8] = '{8'h7F, 4'h8, 8'hF8, 1'b1};

      // Reset held with a pending start request.
      reset     = 1'b0;
      bus.start = 1'b1;
      bus.A     = 8'hFF;
      bus.B     = 4'hF;
      @(negedge clk);
      @(negedge clk);
      check("rst_Y", 32'(bus.Y), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      bus.start = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      check("rst_no_start", 32'(bus.busy), 32'd0);

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].ovf);
      end

      // Start while busy is ignored.
      @(negedge clk);
      bus.start = 1'b1; bus.A = 8'h03; bus.B = 4'h2;
      exp_q.push_back('{8'h06, 1'b0});
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.A = 8'hFF; bus.B = 4'hF;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_ignore", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check("busy_ign_nodone", 32'(bus.done), 32'd0);
      @(negedge clk);
      check("busy_ign_done", 32'(bus.done), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_second_op", 32'(bus.busy | bus.done), 32'd0);
      end

      // Back-to-back: start asserted during the done cycle.
      @(negedge clk);
      bus.start = 1'b1; bus.A = 8'h03; bus.B = 4'h2;
      exp_q.push_back('{8'h06, 1'b0});
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      @(negedge clk);
      check("b2b_done1", 32'(bus.done), 32'd1);
      bus.start = 1'b1; bus.A = 8'h0F; bus.B = 4'h3;
      exp_q.push_back('{8'h2D, 1'b0});
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_accept", 32'(bus.busy), 32'd1);
      check("b2b_pulse", 32'(bus.done), 32'd0);
      for (int i = 0; i < 3; i++) @(negedge clk);
      @(negedge clk);
      check("b2b_done2", 32'(bus.done), 32'd1);
      @(negedge clk);

      // Reset mid-operation discards the partial result.
      bus.start = 1'b1; bus.A = 8'h0F; bus.B = 4'h3;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_Y", 32'(bus.Y), 32'd0);
      check("midrst_ovf", 32'(bus.ovf), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      last_y = 8'h00;
      reset  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("midrst_nodone", 32'(bus.done), 32'd0);
      end
      run_op(8'h0F, 4'h3, 8'h2D, 1'b0);

      @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
